// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_arb_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ADDR_W = 5;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the write-back sources, the register-file write port and decode hazard queries.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
);
    logic              Alu_Valid;
    logic              Alu_Ready;
    logic [ADDR_W-1:0] Alu_Addr;
    logic [DATA_W-1:0] Alu_Data;
    logic              Mem_Valid;
    logic              Mem_Ready;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data;
    logic              Write_Register;
    logic [ADDR_W-1:0] Write_Addr;
    logic [DATA_W-1:0] Write_Data;
    logic [ADDR_W-1:0] Query_Addr1;
    logic [ADDR_W-1:0] Query_Addr2;
    logic              Query_Hazard1;
    logic              Query_Hazard2;
    logic              Last_Grant;

    modport master (
        output Alu_Valid, Alu_Addr, Alu_Data, Mem_Valid, Mem_Addr, Mem_Data,
               Query_Addr1, Query_Addr2,
        input  Alu_Ready, Mem_Ready, Write_Register, Write_Addr, Write_Data,
               Query_Hazard1, Query_Hazard2, Last_Grant
    );

    modport slave (
        input  Alu_Valid, Alu_Addr, Alu_Data, Mem_Valid, Mem_Addr, Mem_Data,
               Query_Addr1, Query_Addr2,
        output Alu_Ready, Mem_Ready, Write_Register, Write_Addr, Write_Data,
               Query_Hazard1, Query_Hazard2, Last_Grant
    );

endinterface

// File: rtl/wb_holding_slot.sv
// One-entry holding slot for a write-back source: handshake, zero-register drop, load/free.
module wb_holding_slot
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              issue,
    output logic              held_valid,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_data
);

    logic accept;

    // A slot being issued this cycle is free again at the edge, so it may reload.
    assign req_ready = Reset_n && (!held_valid || issue);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid <= (req_addr != '0);
        end else if (issue) begin
            held_valid <= 1'b0;
        end
    end

    // Payload is only observed while held_valid is set, so it needs no reset.
    always_ff @(posedge Clock) begin
        if (accept) begin
            held_addr <= req_addr;
            held_data <= req_data;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load write-back.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input logic                    Clock,
    input logic                    Reset_n,
    regfile_write_arbiter_if.slave bus
);

    logic              alu_vld, mem_vld;
    logic [ADDR_W-1:0] alu_addr, mem_addr;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              sel_mem, issue_alu, issue_mem, any_vld;
    logic              last_grant_q;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    function automatic logic reg_hazard(
        input logic [ADDR_W-1:0] q,
        input logic              a_vld,
        input logic [ADDR_W-1:0] a_addr,
        input logic              m_vld,
        input logic [ADDR_W-1:0] m_addr,
        input logic              w_vld,
        input logic [ADDR_W-1:0] w_addr
    );
        return (q != '0) && ((a_vld && a_addr == q) || (m_vld && m_addr == q) ||
                             (w_vld && w_addr == q));
    endfunction

    wb_holding_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .req_valid (bus.Alu_Valid),
        .req_ready (bus.Alu_Ready),
        .req_addr  (bus.Alu_Addr),
        .req_data  (bus.Alu_Data),
        .issue     (issue_alu),
        .held_valid(alu_vld),
        .held_addr (alu_addr),
        .held_data (alu_data)
    );

    wb_holding_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .req_valid (bus.Mem_Valid),
        .req_ready (bus.Mem_Ready),
        .req_addr  (bus.Mem_Addr),
        .req_data  (bus.Mem_Data),
        .issue     (issue_mem),
        .held_valid(mem_vld),
        .held_addr (mem_addr),
        .held_data (mem_data)
    );

    // Same destination: load goes first so the ALU value is what remains in the register.
    always_comb begin
        sel_mem = 1'b0;
        if (mem_vld && !alu_vld) begin
            sel_mem = 1'b1;
        end else if (mem_vld && alu_vld) begin
            sel_mem = (alu_addr == mem_addr) || (last_grant_q == GRANT_ALU);
        end
    end

    assign any_vld   = alu_vld || mem_vld;
    assign issue_alu = alu_vld && !sel_mem;
    assign issue_mem = mem_vld && sel_mem;

    // Stage p1: registered write port toward the register file.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_vld_p1    <= 1'b0;
            wr_addr_p1   <= '0;
            wr_data_p1   <= '0;
            last_grant_q <= GRANT_MEM;
        end else begin
            wr_vld_p1 <= any_vld;
            if (any_vld) begin
                wr_addr_p1   <= sel_mem ? mem_addr : alu_addr;
                wr_data_p1   <= sel_mem ? mem_data : alu_data;
                last_grant_q <= sel_mem ? GRANT_MEM : GRANT_ALU;
            end
        end
    end

    assign bus.Write_Register = wr_vld_p1;
    assign bus.Write_Addr     = wr_addr_p1;
    assign bus.Write_Data     = wr_data_p1;
    assign bus.Last_Grant     = last_grant_q;

    assign bus.Query_Hazard1 = reg_hazard(bus.Query_Addr1, alu_vld, alu_addr, mem_vld, mem_addr,
                                          wr_vld_p1, wr_addr_p1);
    assign bus.Query_Hazard2 = reg_hazard(bus.Query_Addr2, alu_vld, alu_addr, mem_vld, mem_addr,
                                          wr_vld_p1, wr_addr_p1);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a per-cycle behavioural model.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int AW = ARB_ADDR_W;
    localparam int DW = ARB_DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock  (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int wr_pulses = 0;
    logic [DW-1:0] rf_dut [0:(1<<AW)-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural model: two single-entry slots, one issue per cycle by the stated priority rules.
    wb_entry_t m_alu = '0;
    wb_entry_t m_mem = '0;
    logic          m_last  = 1'b1;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    // {something issues, the issued source is Mem}
    function automatic logic [1:0] m_choice();
        if (m_alu.valid && m_mem.valid)
            return {1'b1, (m_alu.addr == m_mem.addr) ? 1'b1 : ~m_last};
        if (m_mem.valid) return 2'b11;
        if (m_alu.valid) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_ready(input logic is_mem);
        logic [1:0] c;
        logic       occ;
        c   = m_choice();
        occ = is_mem ? m_mem.valid : m_alu.valid;
        return rst_n && (!occ || (c[1] && c[0] == is_mem));
    endfunction

    function automatic logic m_haz(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        return (m_alu.valid && m_alu.addr == q) || (m_mem.valid && m_mem.addr == q) ||
               (m_wr && m_waddr == q);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] c;
        logic       ra, rm;
        if (!rst_n) begin
            m_alu = '0; m_mem = '0; m_last = 1'b1;
            m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            c  = m_choice();
            ra = m_ready(1'b0);
            rm = m_ready(1'b1);
            m_wr = c[1];
            if (c[1]) begin
                if (c[0]) begin m_waddr = m_mem.addr; m_wdata = m_mem.data; m_mem.valid = 1'b0; end
                else      begin m_waddr = m_alu.addr; m_wdata = m_alu.data; m_alu.valid = 1'b0; end
                m_last = c[0];
            end
            if (bus.Alu_Valid && ra && bus.Alu_Addr != 0) m_alu = '{1'b1, bus.Alu_Addr, bus.Alu_Data};
            if (bus.Mem_Valid && rm && bus.Mem_Addr != 0) m_mem = '{1'b1, bus.Mem_Addr, bus.Mem_Data};
        end
    end

    always @(posedge clk) begin
        if (bus.Write_Register) begin
            rf_dut[bus.Write_Addr] <= bus.Write_Data;
            wr_pulses <= wr_pulses + 1;
        end
    end

    always @(negedge clk) begin
        chk("alu_ready",  bus.Alu_Ready,      m_ready(1'b0));
        chk("mem_ready",  bus.Mem_Ready,      m_ready(1'b1));
        chk("write_reg",  bus.Write_Register, m_wr);
        chk("write_addr", bus.Write_Addr,     m_waddr);
        chk("write_data", bus.Write_Data,     m_wdata);
        chk("last_grant", bus.Last_Grant,     m_last);
        chk("hazard1",    bus.Query_Hazard1,  m_haz(bus.Query_Addr1));
        chk("hazard2",    bus.Query_Hazard2,  m_haz(bus.Query_Addr2));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic alu_req(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.Alu_Valid = v; bus.Alu_Addr = a; bus.Alu_Data = d;
    endtask

    task automatic mem_req(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.Mem_Valid = v; bus.Mem_Addr = a; bus.Mem_Data = d;
    endtask

    initial begin
        alu_req(1'b0, '0, '0);
        mem_req(1'b0, '0, '0);
        bus.Query_Addr1 = '0;
        bus.Query_Addr2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_write_reg",  bus.Write_Register, 1'b0);
        chk("rst_write_addr", bus.Write_Addr, 0);
        chk("rst_write_data", bus.Write_Data, 0);
        chk("rst_last_grant", bus.Last_Grant, 1'b1);
        chk("rst_alu_ready",  bus.Alu_Ready, 1'b0);
        chk("rst_mem_ready",  bus.Mem_Ready, 1'b0);
        #1 rst_n = 1'b1;

        // ALU only
        @(negedge clk); #1 alu_req(1'b1, 5'd3, 32'hAAAA0001);
        @(negedge clk); #1 alu_req(1'b0, '0, '0);
        @(negedge clk);
        chk("t1_wr", bus.Write_Register, 1'b1);
        chk("t1_addr", bus.Write_Addr, 3);
        chk("t1_data", bus.Write_Data, 32'hAAAA0001);
        @(negedge clk);
        chk("t1_wr_off", bus.Write_Register, 1'b0);

        // simultaneous first requests after reset
        #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        alu_req(1'b1, 5'd4, 32'h44); mem_req(1'b1, 5'd5, 32'h55);
        @(negedge clk);
        chk("t2_mem_ready_lo", bus.Mem_Ready, 1'b0);
        chk("t2_alu_ready_hi", bus.Alu_Ready, 1'b1);
        #1 alu_req(1'b0, '0, '0); mem_req(1'b0, '0, '0);
        @(negedge clk);
        chk("t2_addr_a", bus.Write_Addr, 4);
        chk("t2_lg_a", bus.Last_Grant, 1'b0);
        chk("t2_mem_ready_hi", bus.Mem_Ready, 1'b1);
        @(negedge clk);
        chk("t2_addr_m", bus.Write_Addr, 5);
        chk("t2_data_m", bus.Write_Data, 32'h55);
        chk("t2_lg_m", bus.Last_Grant, 1'b1);
        @(negedge clk);
        chk("t2_wr_off", bus.Write_Register, 1'b0);

        // same destination
        #1 alu_req(1'b1, 5'd7, 32'h11); mem_req(1'b1, 5'd7, 32'h22);
        @(negedge clk); #1 alu_req(1'b0, '0, '0); mem_req(1'b0, '0, '0);
        @(negedge clk);
        chk("t3_first_data", bus.Write_Data, 32'h22);
        chk("t3_first_lg", bus.Last_Grant, 1'b1);
        @(negedge clk);
        chk("t3_second_data", bus.Write_Data, 32'h11);
        chk("t3_second_lg", bus.Last_Grant, 1'b0);
        @(negedge clk);
        chk("t3_rf7", rf_dut[7], 32'h11);

        // zero destination
        #1 alu_req(1'b1, 5'd0, 32'hDEAD); bus.Query_Addr1 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_alu_ready", bus.Alu_Ready, 1'b1);
            chk("t4_haz1", bus.Query_Hazard1, 1'b0);
            chk("t4_wr", bus.Write_Register, 1'b0);
        end
        #1 alu_req(1'b0, '0, '0);

        // hazard lifetime
        #1 bus.Query_Addr2 = 5'd9; mem_req(1'b1, 5'd9, 32'h99);
        #1 chk("t5_haz_before", bus.Query_Hazard2, 1'b0);
        @(negedge clk);
        chk("t5_haz_slot", bus.Query_Hazard2, 1'b1);
        #1 mem_req(1'b0, '0, '0);
        @(negedge clk);
        chk("t5_haz_write", bus.Query_Hazard2, 1'b1);
        chk("t5_addr", bus.Write_Addr, 9);
        @(negedge clk);
        chk("t5_haz_after", bus.Query_Hazard2, 1'b0);

        // both sources streaming
        for (int i = 0; i < 8; i++) begin
            #1 alu_req(1'b1, AW'(12 + (i % 3)), DW'(32'hA000 + i));
            mem_req(1'b1, AW'(20 + (i % 2)), DW'(32'hB000 + i));
            @(negedge clk);
        end
        #1 alu_req(1'b0, '0, '0); mem_req(1'b0, '0, '0);
        repeat (3) @(negedge clk);

        // reset with both slots occupied
        #1 alu_req(1'b1, 5'd10, 32'hA0); mem_req(1'b1, 5'd11, 32'hB0); bus.Query_Addr1 = 5'd11;
        @(negedge clk); #1 alu_req(1'b0, '0, '0); mem_req(1'b0, '0, '0);
        chk("t7_haz_pending", bus.Query_Hazard1, 1'b1);
        @(negedge clk);
        chk("t7_wr_before", bus.Write_Register, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_wr", bus.Write_Register, 1'b0);
        chk("t7_addr", bus.Write_Addr, 0);
        chk("t7_data", bus.Write_Data, 0);
        chk("t7_lg", bus.Last_Grant, 1'b1);
        chk("t7_alu_ready", bus.Alu_Ready, 1'b0);
        chk("t7_mem_ready", bus.Mem_Ready, 1'b0);
        chk("t7_haz1", bus.Query_Hazard1, 1'b0);
        wr_pulses = 0;
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_no_write", wr_pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (`Write_Register`/`Write_Addr`/`Write_Data`) between the two write-back sources of the datapath: the ALU result path and the memory-load result path. Each source hands over a write through a valid/ready handshake into a one-entry holding slot. A round-robin arbiter issues one write per cycle to the register file. The block also reports pending-write hazards for the two read addresses so the decode stage can stall.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register index width (32 registers).

Ports:
- `Clock`  in  1: single clock, all state on rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Alu_Valid`  in  1: ALU write request.
- `Alu_Ready`  out  1: ALU slot can accept.
- `Alu_Addr`  in  ADDR_W: ALU destination register.
- `Alu_Data`  in  DATA_W: ALU result.
- `Mem_Valid`  in  1: load write request.
- `Mem_Ready`  out  1: load slot can accept.
- `Mem_Addr`  in  ADDR_W: load destination register.
- `Mem_Data`  in  DATA_W: load data.
- `Write_Register`  out  1: write enable to the register file (registered).
- `Write_Addr`  out  ADDR_W: write index (registered).
- `Write_Data`  out  DATA_W: write data (registered).
- `Query_Addr1`, `Query_Addr2`  in  ADDR_W: decode-stage read indices.
- `Query_Hazard1`, `Query_Hazard2`  out  1: pending write to the queried register (combinational).
- `Last_Grant`  out  1: 0 = ALU, 1 = Mem; identifies the most recent issued source.

## Operation
- **Slots:** each source has one holding slot (valid, addr, data).
  - `X_Ready` = slot empty OR slot is issued this cycle. Forced 0 while `Reset_n` is low.
  - Accept on `X_Valid && X_Ready` at a rising edge.
- **Register 0:** a request with `X_Addr == 0` is accepted (handshake completes) but not loaded. It never produces a `Write_Register` pulse.
- **Arbitration** each cycle among occupied slots:
  - One occupied slot: it is issued.
  - Both occupied, different addresses: the source not equal to `Last_Grant` is issued.
  - Both occupied, same address: Mem is issued first and ALU second, regardless of `Last_Grant`. The ALU value is the final contents of the register.
- **Issue:** on the edge, the selected entry is registered onto `Write_Addr`/`Write_Data`, `Write_Register` is set to 1, the slot is freed, and `Last_Grant` is updated.
  - If no slot is occupied, `Write_Register` is set to 0. Addr and data hold their previous values.
- **Hazard:** `Query_HazardN` = `Query_AddrN != 0` AND (matches an occupied slot's addr OR (`Write_Register` AND matches `Write_Addr`)).
- **Reset:** asynchronous; clears immediately.
  - Slots empty.
  - `Write_Register` = 0, `Write_Addr` = 0, `Write_Data` = 0.
  - `Last_Grant` = 1, so ALU wins the first conflict.
  - Hazards = 0, Ready = 0.
  - A reset in the middle of operation discards pending slot contents; no write is issued for them.

## Timing
- Request accepted at edge k → `Write_Register` = 1 during the cycle after edge k+1 → register file captures it at edge k+2.
- Single active source: sustained 1 write per cycle; Ready stays high.
- Both sources continuously active: each source gets 1 write per 2 cycles, strictly alternating. The non-granted source sees Ready = 0 while its slot is occupied.
- `Write_Register` is a single-cycle pulse per issued entry. Back-to-back issues keep it high across cycles, with new addr/data each cycle.
- Hazard outputs are combinational from current state and query inputs, with no added latency. They deassert in the cycle after the register file write edge.
- A slot that issues and accepts in the same edge is legal: the freed slot is reloaded with the new request.

## Structure
- Shared package `regfile_arb_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `GRANT_ALU = 1'b0`, `GRANT_MEM = 1'b1`.
  - Typedef `wb_entry_t` {valid, addr, data}.
- Sub-module `wb_holding_slot`, instantiated twice. It owns the handshake, the zero-address drop and the load/free logic.
- Top level holds the arbiter, the output registers, `Last_Grant` and the hazard compare.

## Test plan
- Reset, then ALU only: `Alu_Addr` = 3, `Alu_Data` = 0xAAAA0001 accepted at edge 1 → `Write_Register` = 1, `Write_Addr` = 3, `Write_Data` = 0xAAAA0001 after edge 2; 0 after edge 3 if no further request.
- Simultaneous first requests (ALU addr 4, Mem addr 5) → ALU issued first, Mem next cycle. `Last_Grant` sequence is 0, 1. `Mem_Ready` = 0 for one cycle.
- Same address (both addr 7; ALU data 0x11, Mem data 0x22) → Mem issued first, then ALU; final register-file value is 0x11.
- Zero destination: `Alu_Addr` = 0 accepted → `Alu_Ready` stays 1, `Write_Register` never asserts, `Query_Hazard1` with `Query_Addr1` = 0 stays 0.
- Hazard: Mem addr 9 pending with `Query_Addr2` = 9 → `Query_Hazard2` = 1 from acceptance until the cycle after the register file write edge, then 0.
- Reset asserted with both slots occupied → all outputs return to reset values immediately; no write occurs after `Reset_n` rises.
